mem_access_unit: RTL

//  Load/store unit between the CPU MEM stage and the word-addressed data memory, which has no byte enables.

---
 rtl/mem_access_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store unit between the CPU MEM stage and a word-addressed data memory
// that has no byte enables. Byte and halfword accesses become word accesses.
// Sub-word stores are done as a read-modify-write sequence. Loads are sign- or
// zero-extended. Byte order is little-endian: lane 0 is bits [7:0].
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cpu_valid           request present (sampled only in IDLE)
//   cpu_write           1 = store, 0 = load
//   cpu_size            00 byte, 01 half, 10 word, 11 illegal
//   cpu_signed          loads: 1 = sign-extend, 0 = zero-extend
//   cpu_addr            byte address
//   cpu_wdata           store data (sub-word data taken from low bits)
//   cpu_rdata           registered, extended load result
//   cpu_done            one-cycle completion pulse
//   cpu_err             one-cycle error pulse, concurrent with cpu_done
//   cpu_busy            high whenever the FSM is not IDLE
//   mem_read/mem_write  memory strobes (pure decodes of state)
//   mem_addr            word-aligned memory address
//   mem_wdata           word written to memory
//   mem_rdata           word returned combinationally by the memory
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_valid,
    input  logic                  cpu_write,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_signed,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_done,
    output logic                  cpu_err,
    output logic                  cpu_busy,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                  state_q, state_d;
    logic                    write_q;
    logic [1:0]              size_q;
    logic                    signed_q;
    logic [1:0]              lane_q;
    logic [15:0]             wdata_q;     // only the low half is ever merged
    logic                    err_q;
    logic [31:0]             rdata_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [31:0]             mem_wdata_q;

    // Request legality check on the live CPU fields.
    logic req_err;
    always_comb begin
        req_err = 1'b0;
        case (cpu_size)
            SZ_HALF: req_err = cpu_addr[0];
            SZ_WORD: req_err = (cpu_addr[1:0] != 2'b00);
            SZ_BYTE: req_err = 1'b0;
            default: req_err = 1'b1;
        endcase
    end

    // Per-lane view of the memory word and the read-modify-write merge.
    // A lane is replaced when it is the addressed byte, or belongs to the
    // addressed halfword; halfword lanes take wdata bytes 0/1 in order.
    logic [7:0]  rd_lane    [4];
    logic [31:0] merged_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic hit;
            assign rd_lane[gi] = mem_rdata[gi*8 +: 8];
            assign hit = ((size_q == SZ_BYTE) && (lane_q == 2'(gi))) ||
                         ((size_q == SZ_HALF) && (lane_q[1] == 1'(gi / 2)));
            assign merged_word[gi*8 +: 8] =
                !hit                  ? rd_lane[gi] :
                (size_q == SZ_BYTE)   ? wdata_q[7:0] :
                                        wdata_q[(gi % 2)*8 +: 8];
        end
    endgenerate

    // Load lane extraction and extension.
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    always_comb begin
        load_byte = rd_lane[lane_q];
        load_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_ext = signed_q ? {{24{load_byte[7]}}, load_byte}
                                         : {24'd0, load_byte};
            SZ_HALF: load_ext = signed_q ? {{16{load_half[15]}}, load_half}
                                         : {16'd0, load_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    if (req_err)
                        state_d = RESP;
                    else if (cpu_write && (cpu_size == SZ_WORD))
                        state_d = WR;   // full word: no read needed
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = write_q ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= 16'd0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (cpu_valid) begin
                        write_q  <= cpu_write;
                        size_q   <= cpu_size;
                        signed_q <= cpu_signed;
                        lane_q   <= cpu_addr[1:0];
                        wdata_q  <= cpu_wdata[15:0];
                        err_q    <= req_err;
                        // A rejected request never touches the memory port.
                        if (!req_err) begin
                            mem_addr_q <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                            if (cpu_write && (cpu_size == SZ_WORD))
                                mem_wdata_q <= cpu_wdata;
                        end
                    end
                end
                RD: begin
                    if (write_q)
                        mem_wdata_q <= merged_word;
                    else
                        rdata_q <= load_ext;
                end
                default: ;
            endcase
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_done  = (state_q == RESP);
    assign cpu_err   = (state_q == RESP) && err_q;
    assign cpu_busy  = (state_q != IDLE);
    assign mem_read  = (state_q == RD);
    assign mem_write = (state_q == WR);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
